// File: rtl/regfile_pkg.sv
// Shared register-file constants and the protected-register guard, also used by
// the register file's own write port.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // x0 and sp are never written through the writeback path.
    function automatic logic is_protected(input logic [REG_ADDR_W-1:0] rd);
        return (rd == REG_ZERO) || (rd == REG_SP);
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register busy scoreboard: set at issue, cleared at writeback retire, with
// sticky WAW and orphan-writeback error flags.
module wb_scoreboard
    import regfile_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  set_valid,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr_valid,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic                  err_waw,
    output logic                  err_orphan
);

    logic                set_en;
    logic                clr_en;
    logic                same_rd;
    logic [NUM_REGS-1:0] busy_next;
    logic                waw_hit;
    logic                orphan_hit;

    assign set_en  = set_valid && !is_protected(set_rd);
    assign clr_en  = clr_valid && !is_protected(clr_rd);
    assign same_rd = (set_rd == clr_rd);

    // Clear first, then set: a same-cycle retire and re-issue of one register
    // leaves it busy for the new producer.
    always_comb begin
        busy_next = busy_mask;
        if (clr_en) begin
            busy_next[clr_rd] = 1'b0;
        end
        if (set_en) begin
            busy_next[set_rd] = 1'b1;
        end
    end

    assign waw_hit    = set_en && busy_mask[set_rd] && !(clr_en && same_rd);
    assign orphan_hit = clr_en && !busy_mask[clr_rd] && !(set_en && same_rd);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_mask  <= '0;
            err_waw    <= 1'b0;
            err_orphan <= 1'b0;
        end else begin
            busy_mask <= busy_next;
            if (waw_hit) begin
                err_waw <= 1'b1;
            end
            if (orphan_hit) begin
                err_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the ALU and load writeback paths onto the single register-file
// write port, with ALU starvation protection and a busy scoreboard.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    output logic                  mem_ready,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic                  rf_write_enable,
    output logic [REG_ADDR_W-1:0] rf_addr_rd,
    output logic [XLEN-1:0]       rf_data_rd,
    output logic                  err_waw,
    output logic                  err_orphan
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..7");
    end

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [2:0] wait_cnt;
    logic       force_alu;
    logic       alu_xfer;
    logic       mem_xfer;
    logic       xfer;
    wb_req_t    win_req;
    logic       wr_en;

    // Handshake: a request transfers in the cycle where its valid and ready are
    // both high. Ready depends only on the two valids and wait_cnt, never on the
    // other port's ready; the requester holds valid/rd/data until accepted.
    assign force_alu = (wait_cnt == LIMIT);
    assign alu_ready = alu_valid && (!mem_valid || force_alu);
    assign mem_ready = mem_valid && !(force_alu && alu_valid);

    assign alu_xfer = alu_valid && alu_ready;
    assign mem_xfer = mem_valid && mem_ready;
    assign xfer     = alu_xfer || mem_xfer;

    always_comb begin
        win_req = '{rd: mem_rd, data: mem_data};
        if (alu_xfer) begin
            win_req = '{rd: alu_rd, data: alu_data};
        end
    end

    // Writes to x0/sp are consumed but never reach the register file.
    assign wr_en = xfer && !is_protected(win_req.rd);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 3'd0;
        end else if (!alu_valid || alu_xfer) begin
            wait_cnt <= 3'd0;
        end else if (wait_cnt != LIMIT) begin
            wait_cnt <= wait_cnt + 3'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rf_write_enable <= 1'b0;
            rf_addr_rd      <= '0;
            rf_data_rd      <= '0;
        end else begin
            rf_write_enable <= wr_en;
            if (wr_en) begin
                rf_addr_rd <= win_req.rd;
                rf_data_rd <= win_req.data;
            end
        end
    end

    wb_scoreboard u_scoreboard (
        .clock      (clock),
        .reset_n    (reset_n),
        .set_valid  (issue_valid),
        .set_rd     (issue_rd),
        .clr_valid  (xfer),
        .clr_rd     (win_req.rd),
        .busy_mask  (busy_mask),
        .err_waw    (err_waw),
        .err_orphan (err_orphan)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, starvation and reset
// sequences, then random traffic against a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 3;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] busy_mask;
    logic        rf_write_enable;
    logic [4:0]  rf_addr_rd;
    logic [31:0] rf_data_rd;
    logic        err_waw;
    logic        err_orphan;

    int checks = 0;
    int errors = 0;

    logic [36:0] exp_q[$];

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .alu_valid       (alu_valid),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .alu_ready       (alu_ready),
        .mem_valid       (mem_valid),
        .mem_rd          (mem_rd),
        .mem_data        (mem_data),
        .mem_ready       (mem_ready),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .busy_mask       (busy_mask),
        .rf_write_enable (rf_write_enable),
        .rf_addr_rd      (rf_addr_rd),
        .rf_data_rd      (rf_data_rd),
        .err_waw         (err_waw),
        .err_orphan      (err_orphan)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic assert_reset();
        reset_n = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // drivers
    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                         input logic iv, input logic [4:0] ird);
        alu_valid   = av;
        alu_rd      = ard;
        alu_data    = adat;
        mem_valid   = mv;
        mem_rd      = mrd;
        mem_data    = mdat;
        issue_valid = iv;
        issue_rd    = ird;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rf_write_enable"}, 64'(rf_write_enable), 64'd0);
        check({tag, " rf_addr_rd"}, 64'(rf_addr_rd), 64'd0);
        check({tag, " rf_data_rd"}, 64'(rf_data_rd), 64'd0);
        check({tag, " busy_mask"}, 64'(busy_mask), 64'd0);
        check({tag, " err_waw"}, 64'(err_waw), 64'd0);
        check({tag, " err_orphan"}, 64'(err_orphan), 64'd0);
    endtask

    typedef struct packed {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic        iv;
        logic [4:0]  ird;
        logic        exp_ar;
        logic        exp_mr;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic [31:0] exp_busy;
        logic        exp_waw;
        logic        exp_orph;
    } vec_t;

    vec_t vecs[10];

    // behavioural model state for random traffic
    bit          busy_m[32];
    bit          waw_m;
    bit          orph_m;
    int          losses;
    logic        we_m;
    logic [4:0]  addr_m;
    logic [31:0] data_m;

    function automatic logic [31:0] busy_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = busy_m[i];
        return v;
    endfunction

    function automatic bit prot(input logic [4:0] rd);
        return (rd == 5'd0) || (rd == 5'd2);
    endfunction

    initial begin
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        assert_reset();
        check_all_zero("por");
        check("por alu_ready", 64'(alu_ready), 64'd0);
        check("por mem_ready", 64'(mem_ready), 64'd0);
        release_reset();

        // reset with scoreboard bits set
        drive(0, 0, 0, 0, 0, 0, 1, 5'd3);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 5'd4);
        tick();
        check("preset busy", 64'(busy_mask), 64'h18);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        assert_reset();
        check_all_zero("reset busy");
        release_reset();
        tick();
        check("post-release we", 64'(rf_write_enable), 64'd0);

        vecs[0] = '{0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd5, 0, 0, 0, 5'd0, 32'h0, 32'h20, 0, 0};
        vecs[1] = '{0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0, 0, 5'd0, 32'h0, 32'h20, 0, 0};
        vecs[2] = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, 5'd0, 1, 0, 1, 5'd5, 32'hDEADBEEF, 32'h0, 0, 0};
        vecs[3] = '{1, 5'd0, 32'h1, 0, 5'd0, 32'h0, 0, 5'd0, 1, 0, 0, 5'd5, 32'hDEADBEEF, 32'h0, 0, 0};
        vecs[4] = '{0, 5'd0, 32'h0, 1, 5'd2, 32'h2, 0, 5'd0, 0, 1, 0, 5'd5, 32'hDEADBEEF, 32'h0, 0, 0};
        vecs[5] = '{0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd7, 0, 0, 0, 5'd5, 32'hDEADBEEF, 32'h80, 0, 0};
        vecs[6] = '{0, 5'd0, 32'h0, 1, 5'd7, 32'h77, 1, 5'd7, 0, 1, 1, 5'd7, 32'h77, 32'h80, 0, 0};
        vecs[7] = '{0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd7, 0, 0, 0, 5'd7, 32'h77, 32'h80, 1, 0};
        vecs[8] = '{0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0, 0, 5'd7, 32'h77, 32'h80, 1, 0};
        vecs[9] = '{0, 5'd0, 32'h0, 1, 5'd9, 32'h99, 0, 5'd0, 0, 1, 1, 5'd9, 32'h99, 32'h80, 1, 1};

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].mv, vecs[i].mrd,
                  vecs[i].mdat, vecs[i].iv, vecs[i].ird);
            check($sformatf("v%0d alu_ready", i), 64'(alu_ready), 64'(vecs[i].exp_ar));
            check($sformatf("v%0d mem_ready", i), 64'(mem_ready), 64'(vecs[i].exp_mr));
            tick();
            check($sformatf("v%0d rf_write_enable", i), 64'(rf_write_enable), 64'(vecs[i].exp_we));
            check($sformatf("v%0d rf_addr_rd", i), 64'(rf_addr_rd), 64'(vecs[i].exp_addr));
            check($sformatf("v%0d rf_data_rd", i), 64'(rf_data_rd), 64'(vecs[i].exp_data));
            check($sformatf("v%0d busy_mask", i), 64'(busy_mask), 64'(vecs[i].exp_busy));
            check($sformatf("v%0d err_waw", i), 64'(err_waw), 64'(vecs[i].exp_waw));
            check($sformatf("v%0d err_orphan", i), 64'(err_orphan), 64'(vecs[i].exp_orph));
        end

        // reset mid-stream while a write is on the port
        drive(0, 0, 0, 1, 5'd12, 32'h1234, 0, 0);
        assert_reset();
        check("midreset we", 64'(rf_write_enable), 64'd0);
        check("midreset orphan", 64'(err_orphan), 64'd0);
        check("midreset waw", 64'(err_waw), 64'd0);
        check("midreset busy", 64'(busy_mask), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        release_reset();

        // continuous contention: mem,mem,mem,alu repeating
        for (int c = 0; c < 8; c++) begin
            drive(1, 5'd10, 32'(c), 1, 5'd11, 32'(c + 100), 0, 0);
            check($sformatf("starve c%0d alu_ready", c), 64'(alu_ready), 64'((c % 4) == 3));
            check($sformatf("starve c%0d mem_ready", c), 64'(mem_ready), 64'((c % 4) != 3));
            tick();
            check($sformatf("starve c%0d addr", c), 64'(rf_addr_rd), ((c % 4) == 3) ? 64'd10 : 64'd11);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        assert_reset();
        release_reset();

        // random traffic against the model
        begin
            logic        a_v = 0, m_v = 0;
            logic [4:0]  a_rd = 0, m_rd = 0;
            logic [31:0] a_dat = 0, m_dat = 0;
            logic        iv;
            logic [4:0]  ird;
            bit          alu_win, mem_win, x;
            logic [4:0]  xrd;
            logic [31:0] xdat;
            for (int i = 0; i < 32; i++) busy_m[i] = 0;
            waw_m = 0;
            orph_m = 0;
            losses = 0;
            addr_m = 0;
            data_m = 0;
            for (int cyc = 0; cyc < 600; cyc++) begin
                if (!a_v && $urandom_range(0, 2) != 0) begin
                    a_v = 1;
                    a_rd = 5'($urandom_range(0, 7));
                    a_dat = $urandom;
                end
                if (!m_v && $urandom_range(0, 1) != 0) begin
                    m_v = 1;
                    m_rd = 5'($urandom_range(0, 7));
                    m_dat = $urandom;
                end
                iv = ($urandom_range(0, 3) == 0);
                ird = 5'($urandom_range(0, 7));
                drive(a_v, a_rd, a_dat, m_v, m_rd, m_dat, iv, ird);

                // the ALU wins when uncontended or once it has lost LIMIT times in a row
                alu_win = a_v && (!m_v || losses == LIMIT);
                mem_win = m_v && !alu_win;
                check("rnd alu_ready", 64'(alu_ready), 64'(alu_win));
                check("rnd mem_ready", 64'(mem_ready), 64'(mem_win));

                x = alu_win || mem_win;
                xrd = alu_win ? a_rd : m_rd;
                xdat = alu_win ? a_dat : m_dat;
                we_m = x && !prot(xrd);
                if (we_m) begin
                    if (!busy_m[xrd] && !(iv && ird == xrd)) orph_m = 1;
                    addr_m = xrd;
                    data_m = xdat;
                    exp_q.push_back({xrd, xdat});
                end
                if (iv && !prot(ird) && busy_m[ird] && !(we_m && xrd == ird)) waw_m = 1;
                if (we_m) busy_m[xrd] = 0;
                if (iv && !prot(ird)) busy_m[ird] = 1;
                if (a_v && !alu_win) losses = (losses < LIMIT) ? losses + 1 : LIMIT;
                else losses = 0;
                if (alu_win) a_v = 0;
                if (mem_win) m_v = 0;

                tick();
                check("rnd rf_write_enable", 64'(rf_write_enable), 64'(we_m));
                check("rnd rf_addr_rd", 64'(rf_addr_rd), 64'(addr_m));
                check("rnd rf_data_rd", 64'(rf_data_rd), 64'(data_m));
                check("rnd busy_mask", 64'(busy_mask), 64'(busy_vec()));
                check("rnd err_waw", 64'(err_waw), 64'(waw_m));
                check("rnd err_orphan", 64'(err_orphan), 64'(orph_m));
                if (rf_write_enable === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("rnd unexpected write", 64'(rf_addr_rd), 64'h3f);
                    end else begin
                        check("rnd write stream", 64'({rf_addr_rd, rf_data_rd}), 64'(exp_q.pop_front()));
                    end
                end
            end
            check("rnd writes outstanding", 64'(exp_q.size()), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between two writeback sources: the ALU result path and the load/memory return path. It also keeps a per-register busy scoreboard that decode sets at issue and writeback clears at retire, and it enforces the protected-register policy (x0, x2/sp never written). It sits between execute/memory stages and the register file. Its registered write outputs drive the register file's write_enable/addr_rd/data_rd directly.

## Interface
- STARVE_LIMIT, default 3: consecutive lost ALU arbitration cycles before the ALU is force-granted; legal range 1..7.
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU writeback request
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid  in  1  load writeback request
- mem_rd  in  5  load destination register
- mem_data  in  32  load data
- mem_ready  out  1  load request accepted this cycle
- issue_valid  in  1  decode issued an instruction that writes rd
- issue_rd  in  5  destination of issued instruction
- busy_mask  out  32  bit n set = write to xn outstanding
- rf_write_enable  out  1  to register file write_enable
- rf_addr_rd  out  5  to register file addr_rd
- rf_data_rd  out  32  to register file data_rd
- err_waw  out  1  sticky: issue to an already-busy register
- err_orphan  out  1  sticky: writeback to a non-busy, non-protected register

## Operation
- Transfer on a port occurs when valid && ready in the same cycle. At most one transfer per cycle.
- Ready is combinational from the valids and the starvation counter only. It never depends on the other port's ready.
- Arbitration: mem has fixed priority. alu_ready = alu_valid && (!mem_valid || force_alu). mem_ready = mem_valid && !(force_alu && alu_valid).
- force_alu = (wait_cnt == STARVE_LIMIT).
- wait_cnt (3 bit):
  - increments when alu_valid && !alu_ready;
  - clears when the ALU transfers or alu_valid = 0;
  - saturates at STARVE_LIMIT.
- On a transfer with rd ∉ {0, 2}, the next edge loads rf_write_enable=1, rf_addr_rd=rd, rf_data_rd=data. With no transfer, rf_write_enable=0 and the addr/data outputs hold their last value.
- On a transfer with rd = 0 or 2, the request is consumed (ready=1), rf_write_enable stays 0, and the scoreboard is untouched.
- Scoreboard set: issue_valid with issue_rd ∉ {0, 2} sets busy[issue_rd] at the next edge. Issues to x0/x2 are ignored.
- Scoreboard clear: a transfer clears busy[rd] at the next edge.
- Same cycle, same rd for set and clear: set wins, so the bit stays 1. This is a legal back-to-back reuse.
- err_waw sets when issue_valid targets rd with busy[rd]=1 and that rd is not being cleared this cycle.
- err_orphan sets when a transfer targets rd ∉ {0, 2} with busy[rd]=0 and no same-cycle issue to that rd. The write still proceeds.
- Errors clear only on reset.

## Timing
- Reset (async assert, sync-released by the top level):
  - rf_write_enable=0, rf_addr_rd=0, rf_data_rd=0;
  - busy_mask=0, wait_cnt=0, err_waw=0, err_orphan=0.
- Reset mid-operation drops any accepted-but-unretired write. The register file sees write_enable=0 immediately.
- Latency: transfer in cycle N → rf_* valid in cycle N+1 → register file commits at the end of N+1. busy bit clears visible in N+1.
- Issue in cycle N → busy bit visible in N+1. Decode must therefore check hazards with a one-cycle bypass of its own issue.
- Both valid, counter below limit: mem transfers, ALU waits, counter +1. With STARVE_LIMIT=3, the ALU wins on the 4th contended cycle, then the counter clears.
- Requesters hold valid/rd/data stable until accepted.

## Structure
- Shared package regfile_pkg:
  - XLEN=32, NUM_REGS=32, REG_ADDR_W=5;
  - REG_ZERO=5'd0, REG_SP=5'd2;
  - function is_protected(rd).
- The register file uses the same is_protected function for its own write guard.
- One sub-module, wb_scoreboard: busy_mask, set/clear precedence, and both sticky error flags. The arbiter and output registers stay in the top.

## Test plan
- Reset with busy_mask forced set → after reset_n low, all outputs 0. After release, rf_write_enable=0 until the first transfer.
- Issue x5 in cycle 0, ALU writes x5=0xDEADBEEF in cycle 2 → busy[5]=1 in cycles 1–2. Cycle 3: rf_write_enable=1, rf_addr_rd=5, rf_data_rd=0xDEADBEEF, busy[5]=0. No errors.
- Both ports valid continuously, STARVE_LIMIT=3 → grant sequence mem,mem,mem,alu,mem,mem,mem,alu. Exactly one ready per cycle.
- ALU writes x0=0x1, then mem writes x2=0x2 → both readies assert. rf_write_enable stays 0, busy_mask unchanged, err_orphan=0.
- Same cycle: mem retires x7 and issue x7 → busy[7] stays 1, err_waw=0. Then issue x7 again with no retire → err_waw=1 and stays 1.
- Mem writes x9 with busy[9]=0 → write x9 emitted, err_orphan=1. Assert reset_n=0 mid-stream → err_orphan=0 and rf_write_enable=0 immediately.
